// File: rtl/pipe_elastic_chain_pkg.sv
// ---------------------------------------------------------------------------
// pipe_elastic_chain_pkg
//   Shared constants for the elastic pipeline chain and its users. The
//   ID/EX/MEM stages agree on where each control bit lives, so a bubble
//   (control forced to zero) is harmless to all of them.
//
//   Contents:
//     WORD_SIZE        default payload width
//     CTRL_W_DEFAULT   default control-field width
//     CTRL_*           bit positions inside the control field
//     occ_width()      width of an occupancy count for a given stage count
//     warm_width()     width of the post-reset warm-up counter
// ---------------------------------------------------------------------------
package pipe_elastic_chain_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int CTRL_W_DEFAULT = 8;

    // Control-field bit positions. All are active-high, so an all-zero
    // control field is a safe no-op bubble.
    localparam int CTRL_READM     = 0;
    localparam int CTRL_WRITEM    = 1;
    localparam int CTRL_REGWRITE  = 2;
    localparam int CTRL_HALT      = 3;

    // Each stage holds at most two beats (main + skid), so the count
    // ranges over 0..2*stages.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

    // A zero-length warm-up still needs a one-bit register.
    function automatic int warm_width(input int warmup);
        return (warmup > 0) ? $clog2(warmup + 1) : 1;
    endfunction

endpackage : pipe_elastic_chain_pkg

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//   One elastic stage: a main register M that drives the downstream side and
//   a skid register S that catches a beat arriving while M is stalled. The
//   upstream ready is simply !S.valid taken from a flop, so no combinational
//   ready path runs through the stage.
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     flush_i             kill both held beats at this edge
//     up_valid_i/_data_i/_ctrl_i   incoming beat
//     up_ready_o          stage can take a beat this cycle (registered)
//     down_valid_o/_data_o/_ctrl_o outgoing beat (M register)
//     down_ready_i        downstream takes M this cycle
//     m_valid_d_o, s_valid_d_o     next-state valid bits, for occupancy
// ---------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_elastic_chain_pkg::*;
#(
    parameter int DATA_W = WORD_SIZE,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    output logic              up_ready_o,
    output logic              down_valid_o,
    output logic [DATA_W-1:0] down_data_o,
    output logic [CTRL_W-1:0] down_ctrl_o,
    input  logic              down_ready_i,
    output logic              m_valid_d_o,
    output logic              s_valid_d_o
);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic              accept;

    assign accept = up_valid_i && !s_valid_q;

    // NOTE: every always_comb output gets its hold value first, so no path
    // through the branches below leaves a signal unassigned (no latch).
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ctrl_d  = m_ctrl_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_ctrl_d  = s_ctrl_q;

        if (!m_valid_q || down_ready_i) begin
            // M is free this edge. A held skid beat is older than anything
            // upstream and goes first; upstream is stalled (ready=0) then.
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                m_ctrl_d  = s_ctrl_q;
                s_valid_d = 1'b0;
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_data_d = up_data_i;
                    m_ctrl_d = up_ctrl_i;
                end
            end
        end else if (accept) begin
            // M is stalled; park the beat in S. S is empty here because
            // accept already requires !s_valid_q.
            s_valid_d = 1'b1;
            s_data_d  = up_data_i;
            s_ctrl_d  = up_ctrl_i;
        end

        // Flush overrides any accept or advance in the same cycle.
        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in
    // the chain samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data/ctrl registers are reset too, because the chain's
            // output payload must read zero straight out of reset.
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ctrl_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_ctrl_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ctrl_q  <= m_ctrl_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_ctrl_q  <= s_ctrl_d;
        end
    end

    assign up_ready_o   = !s_valid_q;
    assign down_valid_o = m_valid_q;
    assign down_data_o  = m_data_q;
    assign down_ctrl_o  = m_ctrl_q;
    assign m_valid_d_o  = reset ? 1'b0 : m_valid_d;
    assign s_valid_d_o  = reset ? 1'b0 : s_valid_d;

endmodule : pipe_skid_stage

// File: rtl/pipe_elastic_chain.sv
// ---------------------------------------------------------------------------
// pipe_elastic_chain
//   STAGES skid-buffered pipeline registers chained with valid/ready. Beats
//   keep their order, the chain holds up to 2*STAGES of them, and a full
//   stream moves at one beat per cycle. Adds a synchronous flush, zeroed
//   control on bubbles, a post-reset warm-up hold on in_ready and a
//   registered occupancy count.
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     in_valid_i/_data_i/_ctrl_i upstream beat
//     in_ready_o                 chain accepts a beat this cycle
//     out_valid_o/_data_o/_ctrl_o beat at chain output (ctrl 0 when idle)
//     out_ready_i                downstream accepts (0 = stall)
//     flush_i                    drop every beat held, plus any input beat
//     occupancy_o                number of beats held
//     drained_o                  chain empty and warm-up finished
// ---------------------------------------------------------------------------
module pipe_elastic_chain
    import pipe_elastic_chain_pkg::*;
#(
    parameter int DATA_W = WORD_SIZE,
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int STAGES = 2,
    parameter int WARMUP = 1,
    localparam int OCC_W = occ_width(STAGES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    input  logic              flush_i,
    output logic [OCC_W-1:0]  occupancy_o,
    output logic              drained_o
);

    localparam int WARM_W = warm_width(WARMUP);

    // ---------------- warm-up counter ----------------
    // Loaded on reset, counts down once; a flush does not touch it.
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              warm_done;

    assign warm_done = (warm_q == '0);
    assign warm_d    = warm_done ? warm_q : warm_q - WARM_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q <= WARM_W'(WARMUP);
        end else begin
            warm_q <= warm_d;
        end
    end

    // ---------------- stage chain ----------------
    // Link k is the upstream side of stage k; link STAGES is the output.
    logic [STAGES:0]   link_valid;
    logic [STAGES:0]   link_ready;
    logic [DATA_W-1:0] link_data [STAGES+1];
    logic [CTRL_W-1:0] link_ctrl [STAGES+1];
    logic [STAGES-1:0] m_valid_d;
    logic [STAGES-1:0] s_valid_d;

    // Gating the input valid during warm-up keeps stage 0 from accepting
    // while in_ready_o is forced low.
    assign link_valid[0]      = in_valid_i && warm_done;
    assign link_data[0]       = in_data_i;
    assign link_ctrl[0]       = in_ctrl_i;
    assign link_ready[STAGES] = out_ready_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_skid_stage #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_stage (
            .clk          (clk),
            .reset        (reset),
            .flush_i      (flush_i),
            .up_valid_i   (link_valid[k]),
            .up_data_i    (link_data[k]),
            .up_ctrl_i    (link_ctrl[k]),
            .up_ready_o   (link_ready[k]),
            .down_valid_o (link_valid[k+1]),
            .down_data_o  (link_data[k+1]),
            .down_ctrl_o  (link_ctrl[k+1]),
            .down_ready_i (link_ready[k+1]),
            .m_valid_d_o  (m_valid_d[k]),
            .s_valid_d_o  (s_valid_d[k])
        );
    end

    // ---------------- occupancy ----------------
    // Summing the next-state valid bits makes the registered count change
    // on the same edge as the valid flops themselves.
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OCC_W'(m_valid_d[k]) + OCC_W'(s_valid_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // ---------------- outputs ----------------
    assign in_ready_o  = link_ready[0] && warm_done;
    assign out_valid_o = link_valid[STAGES];
    assign out_data_o  = link_data[STAGES];
    // Bubbles carry an all-zero control field so no stray write/halt leaks.
    assign out_ctrl_o  = out_valid_o ? link_ctrl[STAGES] : '0;
    assign occupancy_o = occ_q;
    assign drained_o   = (occ_q == '0) && warm_done;

endmodule : pipe_elastic_chain
